des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 201 ++++++++++++++++++++
 tb/tb_des_key_schedule.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// des_key_schedule
// Generates DES round subkeys one per handshake from a 64-bit key.
// Encrypt order runs rounds 0..NUM_ROUNDS-1, decrypt order runs NUM_ROUNDS-1..0.
//
// Parameters:
//   NUM_ROUNDS   subkeys per key (1..16)
//   SHIFT_MAP    bit i set -> round i+1 rotates C/D by 2, else by 1
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   key_in         64-bit key, key_in[63] is FIPS bit 1 (parity bits included)
//   decrypt        sampled with the key, selects reverse subkey order
//   key_valid/key_ready       key handshake (ready only while idle)
//   abort          ends a running schedule
//   subkey         PC-2 output, subkey[47] is FIPS bit 1
//   subkey_round   zero-based round index of subkey
//   subkey_valid/subkey_ready subkey handshake
//   busy           schedule in progress
//   parity_err     only with DES_KEY_PARITY_CHECK_EN: some key byte had even parity
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter logic [15:0] SHIFT_MAP  = 16'h7EFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        abort,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    // FIPS 46-3 tables, first entry in the most significant slot.
    localparam logic [56*6-1:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

    localparam logic [48*6-1:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

    function automatic int unsigned total_shift();
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < NUM_ROUNDS; i++)
            s += (((SHIFT_MAP >> i) & 16'h1) != 16'h0) ? 2 : 1;
        return s;
    endfunction

    // Decrypt starts from the last round's C/D: cumulative shift of all rounds.
    localparam int unsigned DEC_SHIFT   = total_shift() % 28;
    localparam int unsigned FIRST_SHIFT = SHIFT_MAP[0] ? 2 : 1;
    localparam logic [3:0]  LAST_ROUND  = 4'(NUM_ROUNDS - 1);

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  n;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            n = 6'(PC1_TAB >> ((55 - i) * 6));
            r[6'(55 - i)] = k[6'(64 - int'(n))];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] c);
        logic [47:0] r;
        logic [5:0]  n;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            n = 6'(PC2_TAB >> ((47 - i) * 6));
            r[6'(47 - i)] = c[6'(56 - int'(n))];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    function automatic logic [27:0] step28(input logic [27:0] x, input logic left, input logic two);
        if (left)
            return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state, state_n;
    logic [55:0] cd, cd_n;
    logic [55:0] key_cd;
    logic [3:0]  round_n, round_inc;
    logic        dec_mode, dec_mode_n;
    logic        enc_two, dec_two, last;

    assign key_cd    = pc1(key_in);
    assign round_inc = subkey_round + 4'd1;
    // Encrypt moves to round subkey_round+1 (map bit subkey_round+1);
    // decrypt undoes the current round's shift (map bit subkey_round).
    assign enc_two   = SHIFT_MAP[round_inc];
    assign dec_two   = SHIFT_MAP[subkey_round];
    assign last      = dec_mode ? (subkey_round == 4'd0) : (subkey_round == LAST_ROUND);

    assign key_ready    = (state == IDLE);
    assign subkey_valid = (state == RUN);
    assign busy         = (state == RUN);

    always_comb begin
        state_n    = state;
        cd_n       = cd;
        round_n    = subkey_round;
        dec_mode_n = dec_mode;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    state_n    = RUN;
                    dec_mode_n = decrypt;
                    if (decrypt) begin
                        cd_n    = {rotl28(key_cd[55:28], DEC_SHIFT), rotl28(key_cd[27:0], DEC_SHIFT)};
                        round_n = LAST_ROUND;
                    end else begin
                        cd_n    = {rotl28(key_cd[55:28], FIRST_SHIFT), rotl28(key_cd[27:0], FIRST_SHIFT)};
                        round_n = '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (subkey_ready) begin
                    if (last) begin
                        state_n = IDLE;
                    end else if (dec_mode) begin
                        cd_n    = {step28(cd[55:28], 1'b0, dec_two), step28(cd[27:0], 1'b0, dec_two)};
                        round_n = subkey_round - 4'd1;
                    end else begin
                        cd_n    = {step28(cd[55:28], 1'b1, enc_two), step28(cd[27:0], 1'b1, enc_two)};
                        round_n = round_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // subkey is registered from cd_n so it always tracks the current CD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cd           <= '0;
            subkey       <= '0;
            subkey_round <= '0;
            dec_mode     <= 1'b0;
        end else begin
            state        <= state_n;
            cd           <= cd_n;
            subkey       <= pc2(cd_n);
            subkey_round <= round_n;
            dec_mode     <= dec_mode_n;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic       key_bad;
    logic [7:0] byte_v;

    // DES keys use odd parity per byte; any even-parity byte flags an error.
    always_comb begin
        key_bad = 1'b0;
        byte_v  = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            byte_v = 8'(key_in >> (8 * b));
            if (!(^byte_v))
                key_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            parity_err <= 1'b0;
        else if (key_valid && state == IDLE)
            parity_err <= key_bad;
    end
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    localparam int NR = 16;
    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        abort = 1'b0;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic        busy;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.NUM_ROUNDS(NR), .SHIFT_MAP(16'h7EFC)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .abort        (abort),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Subkey of zero-based round r: C/D rotated by the cumulative shift,
    // looked up directly through PC-2 then PC-1 in FIPS bit numbering.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        logic [47:0] out;
        int s, p, j, jj, cdi, kb;
        s = 0;
        for (int i = 0; i <= r; i++) s += SHIFTS[i];
        out = '0;
        for (int i = 1; i <= 48; i++) begin
            p   = PC2[i-1];
            j   = (p > 28) ? p - 28 : p;
            jj  = ((j - 1 + s) % 28) + 1;
            cdi = (p > 28) ? 28 + jj : jj;
            kb  = PC1[cdi-1];
            out[48-i] = key[64-kb];
        end
        return out;
    endfunction

    function automatic bit parity_bad(input logic [63:0] k);
        for (int b = 0; b < 8; b++)
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_key(input logic [63:0] key, input bit dec);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic consume(input logic [63:0] key, input bit dec, input bit rnd);
        int n, cyc, er;
        n   = 0;
        cyc = 0;
        while (n < NR && cyc < 400) begin
            er = dec ? NR - 1 - n : n;
            chk("subkey_valid", 64'(subkey_valid), 64'd1);
            chk("subkey", 64'(subkey), 64'(ref_subkey(key, er)));
            chk("subkey_round", 64'(subkey_round), 64'(er));
            chk("busy", 64'(busy), 64'd1);
            chk("key_ready_run", 64'(key_ready), 64'd0);
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_ready) n++;
            cyc++;
            @(negedge clk);
        end
        subkey_ready = 1'b0;
        chk("schedule_len", 64'(n), 64'(NR));
        chk("end_valid", 64'(subkey_valid), 64'd0);
        chk("end_key_ready", 64'(key_ready), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] rk;

        repeat (2) @(negedge clk);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_round", 64'(subkey_round), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key_ready", 64'(key_ready), 64'd1);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", 64'(key_ready), 64'd1);
        chk("idle_abort_busy", 64'(busy), 64'd0);

        start_key(KEY, 1'b0);
        chk("enc_round0_vec", 64'(subkey), 64'h1B02EFFC7072);
        consume(KEY, 1'b0, 1'b0);

        start_key(KEY, 1'b1);
        chk("dec_first_vec", 64'(subkey), 64'hCB3D8B0E17F5);
        chk("dec_first_round", 64'(subkey_round), 64'd15);
        consume(KEY, 1'b1, 1'b0);

        start_key(KEY, 1'b0);
        consume(KEY, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            rk = {$urandom, $urandom};
            start_key(rk, 1'(i % 2));
            consume(rk, 1'(i % 2), 1'b1);
        end

        // Abort together with a handshake at round 5.
        start_key(KEY, 1'b0);
        for (int r = 0; r < 5; r++) begin
            chk("abort_pre_round", 64'(subkey_round), 64'(r));
            subkey_ready = 1'b1;
            @(negedge clk);
        end
        chk("abort_at_round", 64'(subkey_round), 64'd5);
        abort = 1'b1;
        @(negedge clk);
        abort        = 1'b0;
        subkey_ready = 1'b0;
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_key_ready", 64'(key_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        start_key(KEY2, 1'b0);
        chk("restart_round", 64'(subkey_round), 64'd0);
        consume(KEY2, 1'b0, 1'b0);

        // Reset mid-schedule with key_valid held high.
        start_key(KEY, 1'b0);
        for (int r = 0; r < 9; r++) begin
            chk("rst_pre_round", 64'(subkey_round), 64'(r));
            subkey_ready = 1'b1;
            @(negedge clk);
        end
        chk("rst_at_round", 64'(subkey_round), 64'd9);
        rst       = 1'b1;
        key_valid = 1'b1;
        key_in    = KEY2;
        @(negedge clk);
        chk("midrst_subkey", 64'(subkey), 64'd0);
        chk("midrst_round", 64'(subkey_round), 64'd0);
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_key_ready", 64'(key_ready), 64'd1);
        rst          = 1'b0;
        key_valid    = 1'b0;
        subkey_ready = 1'b0;
        @(negedge clk);
        chk("rst_no_accept_busy", 64'(busy), 64'd0);
        chk("rst_no_accept_valid", 64'(subkey_valid), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
        start_key(64'h133457799BBCDFF0, 1'b0);
        chk("parity_bad", 64'(parity_err), 64'(parity_bad(64'h133457799BBCDFF0)));
        consume(64'h133457799BBCDFF0, 1'b0, 1'b0);
        chk("parity_hold", 64'(parity_err), 64'd1);
        start_key(KEY, 1'b0);
        chk("parity_good", 64'(parity_err), 64'(parity_bad(KEY)));
        consume(KEY, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
